// File: rtl/pulse_stretcher.sv
// Stretches single-cycle lock events into pin-visible levels: a solid hold or
// a fixed count of on/off blinks. out and busy are registered for direct pin drive.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 100000000,
  parameter int BLINK_HALF  = 25000000,
  parameter int BLINK_COUNT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  input  logic mode,
  output logic out,
  output logic busy
);

  localparam int CNT_MAX = (HOLD_CYCLES > BLINK_HALF) ? HOLD_CYCLES : BLINK_HALF;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = $clog2(BLINK_COUNT + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SOLID     = 2'd1;
  localparam logic [1:0] BLINK_ON  = 2'd2;
  localparam logic [1:0] BLINK_OFF = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pair_q, pair_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;
  logic          accept_req;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pair_d     = pair_q;
    accept_req = 1'b0;

    case (state_q)
      IDLE: accept_req = 1'b1;
      SOLID: begin
        // Any trig here is a restart: solid reloads, blink aborts the hold.
        if (trig) begin
          accept_req = 1'b1;
        end else if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BLINK_ON: begin
        if (cnt_q <= CW'(1)) begin
          state_d = BLINK_OFF;
          cnt_d   = CW'(BLINK_HALF);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      BLINK_OFF: begin
        if (cnt_q <= CW'(1)) begin
          if (pair_q > PW'(1)) begin
            state_d = BLINK_ON;
            cnt_d   = CW'(BLINK_HALF);
            pair_d  = pair_q - PW'(1);
          end else begin
            // Pattern ends this edge; a coincident trig starts a new one.
            state_d    = IDLE;
            accept_req = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept_req && trig) begin
      if (mode) begin
        state_d = BLINK_ON;
        cnt_d   = CW'(BLINK_HALF);
        pair_d  = PW'(BLINK_COUNT);
      end else begin
        state_d = SOLID;
        cnt_d   = CW'(HOLD_CYCLES);
      end
    end

    out_d  = (state_d == SOLID) || (state_d == BLINK_ON);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pair_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pair_q  <= pair_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;

endmodule
